// File: rtl/wbuffer_fifo_param_if.sv
// Bundle of the cache-side request/lookup/clear signals and the AXI write channel
// of the write-back buffer. The slave modport is the buffer; master is its environment.
interface wbuffer_fifo_param_if #(
   parameter int DEPTH      = 16,
   parameter int LINE_WORDS = 8,
   parameter int PADDR_W    = 32
);
   localparam int OFS_W  = $clog2(LINE_WORDS * 4);
   localparam int TAG_W  = PADDR_W - OFS_W;
   localparam int LINE_W = 32 * LINE_WORDS;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              wreq_valid;
   logic              wreq_ready;
   logic [TAG_W-1:0]  wreq_tag;
   logic [LINE_W-1:0] wreq_data;
   logic [TAG_W-1:0]  lookup_tag;
   logic              lookup_hit;
   logic [LINE_W-1:0] lookup_data;
   logic              clear_req;
   logic              clear_done;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic [PADDR_W-1:0] awaddr;
   logic [3:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   logic              bvalid;
   logic              bready;

   modport master (
      output wreq_valid, wreq_tag, wreq_data, lookup_tag, clear_req, awready, wready, bvalid,
      input  wreq_ready, lookup_hit, lookup_data, clear_done, empty, count,
             awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready
   );

   modport slave (
      input  wreq_valid, wreq_tag, wreq_data, lookup_tag, clear_req, awready, wready, bvalid,
      output wreq_ready, lookup_hit, lookup_data, clear_done, empty, count,
             awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready
   );
endinterface

// File: rtl/wbuffer_fifo_param.sv
// Write-back buffer: circular FIFO of dirty lines with in-place merge, youngest-copy
// lookup and background drain to AXI as INCR bursts with bounded outstanding B.
module wbuffer_fifo_param #(
   parameter int DEPTH           = 16,
   parameter int LINE_WORDS      = 8,
   parameter int PADDR_W         = 32,
   parameter int DRAIN_THRESH    = 12,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic clk,
   input logic rst,
   wbuffer_fifo_param_if.slave bus_io
);
   localparam int OFS_W  = $clog2(LINE_WORDS * 4);
   localparam int TAG_W  = PADDR_W - OFS_W;
   localparam int LINE_W = 32 * LINE_WORDS;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BEAT_W = $clog2(LINE_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

   logic [TAG_W-1:0]  tag_q  [DEPTH];
   logic [LINE_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [3:0]        outst_q, outst_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              clr_pend_q, clr_pend_d;
   state_t            state_q, state_d;

   logic              draining, accept, alloc, aw_hs, last_hs, b_ret, clr_done;
   logic              look_hit, merge_hit;
   logic [PTR_W-1:0]  look_idx, merge_idx, wr_idx, idx;
   logic [LINE_W-1:0] head_data;

   assign draining = (state_q != S_IDLE);

   // Scan from head so the last match seen is the youngest copy of a tag.
   always_comb begin
      look_hit  = 1'b0;
      look_idx  = head_q;
      merge_hit = 1'b0;
      merge_idx = head_q;
      idx       = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (valid_q[idx] && tag_q[idx] == bus_io.lookup_tag) begin
            look_hit = 1'b1;
            look_idx = idx;
         end
         if (valid_q[idx] && tag_q[idx] == bus_io.wreq_tag && !(draining && i == 0)) begin
            merge_hit = 1'b1;
            merge_idx = idx;
         end
      end
   end

   assign bus_io.wreq_ready  = merge_hit || (count_q < CNT_W'(DEPTH));
   assign accept   = bus_io.wreq_valid && bus_io.wreq_ready;
   assign alloc    = accept && !merge_hit;
   assign wr_idx   = merge_hit ? merge_idx : tail_q;
   assign aw_hs    = (state_q == S_AW) && bus_io.awready;
   assign last_hs  = (state_q == S_W) && bus_io.wready && (beat_q == BEAT_W'(LINE_WORDS - 1));
   assign b_ret    = bus_io.bvalid && (outst_q != 4'd0);
   assign clr_done = clr_pend_q && (count_q == '0) && (outst_q == 4'd0) && (state_q == S_IDLE);

   always_comb begin
      count_d = count_q;
      if (alloc && !last_hs)      count_d = count_q + 1'b1;
      else if (!alloc && last_hs) count_d = count_q - 1'b1;
      outst_d = outst_q;
      if (aw_hs && !b_ret)        outst_d = outst_q + 1'b1;
      else if (!aw_hs && b_ret)   outst_d = outst_q - 1'b1;
      clr_pend_d = clr_done ? 1'b0 : (clr_pend_q || bus_io.clear_req);
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         S_IDLE: if (count_q != '0 && outst_q < 4'(MAX_OUTSTANDING) &&
                     (count_q >= CNT_W'(DRAIN_THRESH) || clr_pend_q))
                    state_d = S_AW;
         S_AW: if (bus_io.awready) begin
                  state_d = S_W;
                  beat_d  = '0;
               end
         S_W: if (bus_io.wready) begin
                 beat_d = beat_q + 1'b1;
                 if (beat_q == BEAT_W'(LINE_WORDS - 1)) state_d = S_IDLE;
              end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         outst_q    <= 4'd0;
         beat_q     <= '0;
         clr_pend_q <= 1'b0;
         state_q    <= S_IDLE;
      end else begin
         if (last_hs) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         if (alloc) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         count_q    <= count_d;
         outst_q    <= outst_d;
         beat_q     <= beat_d;
         clr_pend_q <= clr_pend_d;
         state_q    <= state_d;
      end
   end

   // Line storage needs no reset; valid_q qualifies every read.
   always_ff @(posedge clk) begin
      if (accept) begin
         tag_q[wr_idx]  <= bus_io.wreq_tag;
         data_q[wr_idx] <= bus_io.wreq_data;
      end
   end

   assign head_data = data_q[head_q];

   assign bus_io.lookup_hit  = look_hit;
   assign bus_io.lookup_data = look_hit ? data_q[look_idx] : '0;
   assign bus_io.clear_done  = clr_done;
   assign bus_io.empty       = (count_q == '0) && (outst_q == 4'd0);
   assign bus_io.count       = count_q;
   assign bus_io.awaddr      = {tag_q[head_q], {OFS_W{1'b0}}};
   assign bus_io.awlen       = 4'(LINE_WORDS - 1);
   assign bus_io.awsize      = 3'b010;
   assign bus_io.awburst     = 2'b01;
   assign bus_io.awvalid     = (state_q == S_AW);
   assign bus_io.wdata       = head_data[32*beat_q +: 32];
   assign bus_io.wstrb       = 4'hF;
   assign bus_io.wlast       = (state_q == S_W) && (beat_q == BEAT_W'(LINE_WORDS - 1));
   assign bus_io.wvalid      = (state_q == S_W);
   assign bus_io.bready      = 1'b1;
endmodule

// File: tb/tb_wbuffer_fifo_param.sv
// Directed bench for wbuffer_fifo_param: expected bursts are queued by the stimulus
// and consumed by a monitor watching the AW/W channels.
module tb_wbuffer_fifo_param;
   localparam int DEPTH = 16, LW = 8, PW = 32, TH = 12, MO = 2;

   typedef struct {
      logic [31:0]  addr;
      logic [255:0] data;
   } burst_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wbuffer_fifo_param_if #(.DEPTH(DEPTH), .LINE_WORDS(LW), .PADDR_W(PW)) bus ();

   wbuffer_fifo_param #(
      .DEPTH(DEPTH), .LINE_WORDS(LW), .PADDR_W(PW), .DRAIN_THRESH(TH), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst), .bus_io(bus)
   );

   int     n_chk = 0, n_fail = 0;
   burst_t expq[$];
   burst_t cur;
   int     mbeat = 0, aw_hs = 0, done_cnt = 0;
   int     b_sent = 0, b_used = 0, b_grant = 0;
   bit     b_auto = 1'b1;

   task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic fail_now(string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event did not occur as required", name);
   endtask

   function automatic logic [255:0] mk(int tag, int seed);
      logic [255:0] v;
      for (int k = 0; k < LW; k++) v[32*k +: 32] = {8'(seed), 8'(tag >> 8), 8'(tag), 8'(k)};
      return v;
   endfunction

   task automatic push(int tag, logic [255:0] d);
      burst_t b;
      b.addr = 32'(tag) << 5;
      b.data = d;
      expq.push_back(b);
   endtask

   // Monitor: pops one expected burst per AW handshake and checks every W beat against it.
   always @(negedge clk) begin
      if (rst) begin
         mbeat = 0;
      end else begin
         if (bus.clear_done) done_cnt++;
         if (bus.awvalid && bus.awready) begin
            aw_hs++;
            if (expq.size() == 0) fail_now("aw_unexpected");
            else begin
               cur = expq.pop_front();
               chk("awaddr", bus.awaddr, cur.addr);
               chk("awlen", bus.awlen, 7);
               chk("awsize", bus.awsize, 2);
               chk("awburst", bus.awburst, 1);
            end
            mbeat = 0;
         end
         if (bus.wvalid && bus.wready) begin
            chk("wdata", bus.wdata, cur.data[32*mbeat +: 32]);
            chk("wlast", bus.wlast, (mbeat == LW - 1));
            chk("wstrb", bus.wstrb, 4'hF);
            mbeat++;
         end
      end
   end

   // B responder: one response per AW, automatic or released one at a time by b_grant.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         bus.bvalid = 1'b0;
         b_sent     = aw_hs;
      end else begin
         bus.bvalid = 1'b0;
         if (aw_hs > b_sent && (b_auto || b_grant > b_used)) begin
            bus.bvalid = 1'b1;
            b_sent++;
            if (!b_auto) b_used++;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(int tag, logic [255:0] d);
      int i = 0;
      bit ok = 1'b0;
      bus.wreq_valid = 1'b1;
      bus.wreq_tag   = 27'(tag);
      bus.wreq_data  = d;
      while (!ok && i < 200) begin
         @(negedge clk);
         ok = bus.wreq_ready;
         @(posedge clk);
         #1;
         i++;
      end
      bus.wreq_valid = 1'b0;
      if (!ok) fail_now("wr_timeout");
   endtask

   task automatic do_clear(string name, int budget);
      int d0 = done_cnt;
      int i = 0;
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      while (done_cnt == d0 && i < budget) begin
         tick();
         i++;
      end
      chk(name, (done_cnt > d0), 1);
   endtask

   task automatic wait_wvalid(int budget);
      int i = 0;
      while (!bus.wvalid && i < budget) begin
         tick();
         i++;
      end
      chk("wvalid_seen", bus.wvalid, 1);
   endtask

   initial begin
      int a0, d0;
      bus.wreq_valid = 1'b0;
      bus.wreq_tag   = '0;
      bus.wreq_data  = '0;
      bus.lookup_tag = '0;
      bus.clear_req  = 1'b0;
      bus.awready    = 1'b1;
      bus.wready     = 1'b1;

      // Reset state
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_awvalid", bus.awvalid, 0);
      chk("rst_wvalid", bus.wvalid, 0);
      chk("rst_wlast", bus.wlast, 0);
      chk("rst_clear_done", bus.clear_done, 0);
      chk("rst_lookup_hit", bus.lookup_hit, 0);
      chk("rst_wreq_ready", bus.wreq_ready, 1);
      chk("rst_empty", bus.empty, 1);
      chk("rst_count", bus.count, 0);
      tick();

      // Threshold: 11 lines stay queued, the 12th starts a drain
      for (int i = 0; i < 11; i++) wr(16 + i, mk(16 + i, 1));
      @(negedge clk);
      chk("t1_count11", bus.count, 11);
      chk("t1_awvalid_idle", bus.awvalid, 0);
      chk("t1_no_aw", aw_hs, 0);
      tick();
      push(16, mk(16, 1));
      wr(27, mk(27, 1));
      @(negedge clk);
      chk("t1_count12", bus.count, 12);
      chk("t1_awvalid_pre", bus.awvalid, 0);
      @(negedge clk);
      chk("t1_awvalid", bus.awvalid, 1);
      chk("t1_awaddr", bus.awaddr, 32'h200);
      chk("t1_awlen", bus.awlen, 7);
      tick(20);
      chk("t1_count_after", bus.count, 11);
      for (int i = 1; i < 12; i++) push(16 + i, mk(16 + i, 1));
      do_clear("t1_clear_done", 2000);
      chk("t1_empty", bus.empty, 1);
      chk("t1_queue", expq.size(), 0);

      // Merge of a rewritten line
      wr(32'h100, mk(32'h100, 2));
      wr(32'h100, mk(32'h100, 3));
      @(negedge clk);
      chk("t2_count", bus.count, 1);
      bus.lookup_tag = 27'h100;
      #1;
      chk("t2_hit", bus.lookup_hit, 1);
      chk("t2_data", bus.lookup_data, mk(32'h100, 3));
      tick();
      push(32'h100, mk(32'h100, 3));
      a0 = aw_hs;
      do_clear("t2_clear_done", 500);
      chk("t2_one_burst", aw_hs - a0, 1);
      chk("t2_b_done", b_sent, aw_hs);
      chk("t2_empty", bus.empty, 1);

      // Full FIFO with AW stalled, merge while full, wrap of head
      bus.awready = 1'b0;
      for (int i = 0; i < 16; i++) wr(32'h200 + i, mk(32'h200 + i, 4));
      @(negedge clk);
      chk("t3_count16", bus.count, 16);
      chk("t3_awvalid", bus.awvalid, 1);
      tick();
      bus.wreq_tag = 27'h300;
      #1;
      chk("t3_ready_new", bus.wreq_ready, 0);
      bus.wreq_tag = 27'h205;
      #1;
      chk("t3_ready_queued", bus.wreq_ready, 1);
      bus.wreq_tag = 27'h200;
      #1;
      chk("t3_ready_head", bus.wreq_ready, 0);
      tick();
      wr(32'h205, mk(32'h205, 9));
      @(negedge clk);
      chk("t3_count_merge", bus.count, 16);
      tick();
      for (int i = 0; i < 16; i++) push(32'h200 + i, (i == 5) ? mk(32'h205, 9) : mk(32'h200 + i, 4));
      bus.awready = 1'b1;
      do_clear("t3_clear_done", 3000);
      chk("t3_count0", bus.count, 0);
      chk("t3_queue", expq.size(), 0);

      // Rewrite of the head line while its burst is stalled
      push(32'h40, mk(32'h40, 5));
      push(32'h40, mk(32'h40, 6));
      wr(32'h40, mk(32'h40, 5));
      bus.wready    = 1'b0;
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      wait_wvalid(50);
      bus.wready = 1'b1;
      tick(3);
      bus.wready = 1'b0;
      wr(32'h40, mk(32'h40, 6));
      @(negedge clk);
      chk("t4_count", bus.count, 2);
      bus.lookup_tag = 27'h40;
      #1;
      chk("t4_hit", bus.lookup_hit, 1);
      chk("t4_data", bus.lookup_data, mk(32'h40, 6));
      tick();
      bus.wready = 1'b1;
      d0 = done_cnt;
      for (int i = 0; i < 500 && done_cnt == d0; i++) tick();
      chk("t4_clear_done", (done_cnt > d0), 1);
      chk("t4_queue", expq.size(), 0);

      // Outstanding limit of 2 with B responses released one at a time
      b_auto = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr(32'h500 + i, mk(32'h500 + i, 7));
         push(32'h500 + i, mk(32'h500 + i, 7));
      end
      a0 = aw_hs;
      d0 = done_cnt;
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      tick(80);
      chk("t5_aw_limit", aw_hs - a0, 2);
      for (int k = 1; k <= 3; k++) begin
         b_grant++;
         tick(40);
         chk("t5_aw_after_b", aw_hs - a0, (k < 3) ? 2 + k : 4);
         chk("t5_no_done_yet", done_cnt - d0, 0);
      end
      b_grant++;
      for (int i = 0; i < 100 && done_cnt == d0; i++) tick();
      chk("t5_done_after_4th_b", done_cnt - d0, 1);
      chk("t5_empty", bus.empty, 1);
      b_auto = 1'b1;

      // Reset in the middle of a burst
      wr(32'h600, mk(32'h600, 8));
      push(32'h600, mk(32'h600, 8));
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      wait_wvalid(50);
      tick(3);
      bus.lookup_tag = 27'h600;
      #1;
      chk("t6_hit_before", bus.lookup_hit, 1);
      rst = 1'b1;
      tick();
      chk("t6_awvalid", bus.awvalid, 0);
      chk("t6_wvalid", bus.wvalid, 0);
      chk("t6_count", bus.count, 0);
      chk("t6_empty", bus.empty, 1);
      chk("t6_lookup_hit", bus.lookup_hit, 0);
      rst = 1'b0;
      tick(2);
      chk("final_queue", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
